// File: rtl/tlc_phase_arbiter.sv
// Round-robin GREEN/YELLOW/ALL_RED scheduler for four traffic approaches.
// Ports: clk, reset (async, active-low), ena, tick, peak, req[3:0] in;
//        tl[7:0], grant[3:0], timer[7:0], phase[1:0] out, all registered.
module tlc_phase_arbiter #(
  parameter int GREEN_PEAK = 30,
  parameter int GREEN_OFF  = 15,
  parameter int MIN_GREEN  = 5,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       tick,
  input  logic       peak,
  input  logic [3:0] req,
  output logic [7:0] tl,
  output logic [3:0] grant,
  output logic [7:0] timer,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_pend;
  logic [1:0] r_last;
  logic [3:0] r_grant;
  logic [7:0] r_timer;
  logic [7:0] r_dur;
  logic [7:0] r_tl;

  logic       w_win_vld;
  logic [1:0] w_win;
  logic [3:0] w_win_oh;
  logic [3:0] w_cap;
  logic [7:0] w_dur_new;
  logic [8:0] w_elapsed;
  logic       w_gap;

  function automatic logic [7:0] f_tl(
    input logic [3:0] g,
    input logic [1:0] c
  );
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 4; i++)
      if (g[i]) t[2*i +: 2] = c;
    return t;
  endfunction

  // Search starts just after the last served approach.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_win_vld && r_pend[r_last + 2'(k)]) begin
        w_win_vld = 1'b1;
        w_win     = r_last + 2'(k);
      end
    end
  end

  assign w_win_oh  = 4'b0001 << w_win;
  assign w_dur_new = peak ? 8'(GREEN_PEAK) : 8'(GREEN_OFF);

  // The green approach may not queue itself again while green.
  assign w_cap = r_pend |
    (req & ~((r_state == S_GREEN) ? r_grant : 4'b0000));

  // Ticks of green already shown, including the current one.
  assign w_elapsed = {1'b0, r_dur} - {1'b0, r_timer} + 9'd1;

  assign w_gap = (w_elapsed >= 9'(MIN_GREEN)) &&
                 !(|(req & r_grant)) &&
                 (|(r_pend & ~r_grant));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_last  <= 2'd3;
      r_grant <= '0;
      r_timer <= '0;
      r_dur   <= '0;
      r_tl    <= '0;
    end else if (ena) begin
      r_pend <= w_cap;
      if (tick) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_win_vld) begin
              r_state <= S_GREEN;
              r_grant <= w_win_oh;
              r_last  <= w_win;
              r_pend  <= w_cap & ~w_win_oh;
              r_timer <= w_dur_new;
              r_dur   <= w_dur_new;
              r_tl    <= f_tl(w_win_oh, 2'd2);
            end else begin
              r_timer <= '0;
            end
          end
          S_GREEN: begin
            if (r_timer == 8'd1 || w_gap) begin
              r_state <= S_YELLOW;
              r_timer <= 8'(YELLOW_T);
              r_tl    <= f_tl(r_grant, 2'd1);
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
          S_YELLOW: begin
            if (r_timer == 8'd1) begin
              r_state <= S_ALLRED;
              r_timer <= 8'(ALLRED_T);
              r_tl    <= '0;
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
          S_ALLRED: begin
            if (r_timer == 8'd1) begin
              if (w_win_vld) begin
                r_state <= S_GREEN;
                r_grant <= w_win_oh;
                r_last  <= w_win;
                r_pend  <= w_cap & ~w_win_oh;
                r_timer <= w_dur_new;
                r_dur   <= w_dur_new;
                r_tl    <= f_tl(w_win_oh, 2'd2);
              end else begin
                r_state <= S_IDLE;
                r_grant <= '0;
                r_timer <= '0;
              end
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign tl    = r_tl;
  assign grant = r_grant;
  assign timer = r_timer;
  assign phase = r_state;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Scoreboard bench for tlc_phase_arbiter: directed scenarios plus
// randomized traffic against an abstract reference model.
module tb_tlc_phase_arbiter;

  localparam int GP = 30;
  localparam int GO = 15;
  localparam int MG = 5;
  localparam int YT = 3;
  localparam int AR = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       tick = 1'b0;
  logic       peak = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [7:0] tl;
  logic [3:0] grant;
  logic [7:0] timer;
  logic [1:0] phase;

  always #5 clk = ~clk;

  tlc_phase_arbiter #(
    .GREEN_PEAK(GP),
    .GREEN_OFF (GO),
    .MIN_GREEN (MG),
    .YELLOW_T  (YT),
    .ALLRED_T  (AR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ena  (ena),
    .tick (tick),
    .peak (peak),
    .req  (req),
    .tl   (tl),
    .grant(grant),
    .timer(timer),
    .phase(phase)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [21:0] exp_q[$];
  logic [21:0] e;

  // Reference model: phase as 0..3, gnt as index (-1 none).
  int m_ph = 0;
  int m_rem = 0;
  int m_last = 3;
  int m_gnt = -1;
  int m_dur = 0;
  int m_pend[4] = '{0, 0, 0, 0};

  task automatic start_green(input int w, input bit pk);
    m_ph   = 1;
    m_gnt  = w;
    m_last = w;
    m_rem  = pk ? GP : GO;
    m_dur  = m_rem;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit tk,
                            input bit pk, input logic [3:0] rq);
    int np[4];
    int w;
    int oth;
    if (!rst) begin
      m_ph = 0; m_rem = 0; m_last = 3; m_gnt = -1; m_dur = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      return;
    end
    if (!en) return;
    for (int i = 0; i < 4; i++)
      np[i] = (m_pend[i] != 0 ||
               (rq[i] && !(m_ph == 1 && m_gnt == i))) ? 1 : 0;
    if (tk) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && m_pend[(m_last + k) % 4] != 0) w = (m_last + k) % 4;
      oth = 0;
      for (int i = 0; i < 4; i++)
        if (i != m_gnt && m_pend[i] != 0) oth = 1;
      case (m_ph)
        0: begin
          if (w >= 0) begin start_green(w, pk); np[w] = 0; end
          else m_rem = 0;
        end
        1: begin
          if (m_rem == 1 ||
              ((m_dur - m_rem + 1) >= MG && !rq[m_gnt] && oth != 0)) begin
            m_ph = 2; m_rem = YT;
          end else m_rem--;
        end
        2: begin
          if (m_rem == 1) begin m_ph = 3; m_rem = AR; end
          else m_rem--;
        end
        default: begin
          if (m_rem == 1) begin
            if (w >= 0) begin start_green(w, pk); np[w] = 0; end
            else begin m_ph = 0; m_gnt = -1; m_rem = 0; end
          end else m_rem--;
        end
      endcase
    end
    m_pend = np;
  endtask

  function automatic logic [21:0] model_out();
    logic [7:0] t;
    logic [3:0] g;
    t = '0;
    g = '0;
    if (m_gnt >= 0) begin
      g[m_gnt] = 1'b1;
      t[2*m_gnt +: 2] = (m_ph == 1) ? 2'd2 : (m_ph == 2) ? 2'd1 : 2'd0;
    end
    return {t, g, 8'(m_rem), 2'(m_ph)};
  endfunction

  task automatic drive(input bit rst, input bit en, input bit tk,
                       input bit pk, input logic [3:0] rq);
    @(negedge clk);
    #1;
    reset = rst; ena = en; tick = tk; peak = pk; req = rq;
    model_step(rst, en, tk, pk, rq);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit pk, input logic [3:0] rq);
    repeat (n) drive(1'b1, 1'b1, 1'b1, pk, rq);
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({tl, grant, timer, phase} !== e) begin
        n_bad++;
        $display("FAIL sb @%0t: got tl=%h gnt=%b tmr=%0d ph=%0d exp tl=%h gnt=%b tmr=%0d ph=%0d",
                 $time, tl, grant, timer, phase,
                 e[21:14], e[13:10], e[9:2], e[1:0]);
      end
    end
  end

  initial begin
    logic [3:0] rq;
    bit pk;

    drive(0, 1, 1, 0, 4'h0);
    drive(0, 1, 1, 0, 4'hf);
    chk("rst_phase", phase, 0);
    chk("rst_tl", tl, 0);
    chk("rst_grant", grant, 0);

    // single request, off-peak full cycle
    drive(1, 1, 1, 0, 4'b0001);
    drive(1, 1, 1, 0, 4'b0000);
    chk("t1_phase_g", phase, 1);
    chk("t1_grant", grant, 1);
    chk("t1_timer", timer, GO);
    run(14, 0, 4'h0);
    chk("t1_timer_last", timer, 1);
    run(1, 0, 4'h0);
    chk("t1_phase_y", phase, 2);
    chk("t1_tl_y", int'(tl[1:0]), 1);
    run(3, 0, 4'h0);
    chk("t1_phase_ar", phase, 3);
    run(1, 0, 4'h0);
    chk("t1_idle", phase, 0);
    chk("t1_idle_tmr", timer, 0);

    // all requesting, peak: strict rotation, full 30-tick greens
    drive(0, 1, 1, 1, 4'hf);
    drive(1, 1, 1, 1, 4'hf);
    drive(1, 1, 1, 1, 4'hf);
    chk("t2_grant0", grant, 1);
    chk("t2_timer0", timer, GP);
    for (int n = 1; n <= 4; n++) begin
      run(34, 1, 4'hf);
      chk("t2_grant", grant, 1 << (n % 4));
      chk("t2_timer", timer, GP);
    end

    // gap-out at MIN_GREEN
    drive(0, 1, 1, 0, 4'h0);
    drive(1, 1, 1, 0, 4'b0100);
    drive(1, 1, 1, 0, 4'b0100);
    chk("t3_grant", grant, 4);
    drive(1, 1, 1, 0, 4'b0000);
    drive(1, 1, 1, 0, 4'b0001);
    run(2, 0, 4'h0);
    chk("t3_still_g", phase, 1);
    run(1, 0, 4'h0);
    chk("t3_gapout", phase, 2);
    run(4, 0, 4'h0);
    chk("t3_next", grant, 1);
    chk("t3_next_ph", phase, 1);

    // peak change mid-green
    drive(0, 1, 1, 0, 4'h0);
    drive(1, 1, 1, 0, 4'b0001);
    drive(1, 1, 1, 0, 4'b0001);
    run(14, 1, 4'b0011);
    chk("t4_green_len", timer, 1);
    run(1, 1, 4'b0011);
    chk("t4_yellow", phase, 2);
    run(4, 1, 4'b0011);
    chk("t4_grant", grant, 2);
    chk("t4_peak_dur", timer, GP);

    // freeze mid-yellow
    drive(0, 1, 1, 0, 4'h0);
    drive(1, 1, 1, 0, 4'b0001);
    drive(1, 1, 1, 0, 4'b0000);
    run(16, 0, 4'h0);
    chk("t5_pre", timer, 2);
    repeat (10) drive(1, 0, 1, 0, 4'($urandom));
    chk("t5_tmr", timer, 2);
    chk("t5_ph", phase, 2);
    chk("t5_tl", tl, 1);
    run(2, 0, 4'h0);
    chk("t5_ar", phase, 3);
    run(1, 0, 4'h0);
    chk("t5_idle", phase, 0);

    // asynchronous reset mid-green
    drive(0, 1, 1, 0, 4'h0);
    drive(1, 1, 1, 0, 4'b0001);
    drive(1, 1, 1, 0, 4'b0000);
    run(3, 0, 4'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_tl", tl, 0);
    chk("t6_grant", grant, 0);
    chk("t6_timer", timer, 0);
    chk("t6_phase", phase, 0);
    model_step(0, ena, tick, peak, req);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    drive(1, 1, 1, 0, 4'hf);
    drive(1, 1, 1, 0, 4'hf);
    chk("t6_first", grant, 1);

    // randomized traffic
    rq = 4'h0;
    pk = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 4) == 0) rq = 4'($urandom & $urandom);
      if ($urandom_range(0, 99) == 0) pk = ~pk;
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 2) != 0, pk, rq);
    end

    @(negedge clk);
    #2;
    chk("q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
